// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage load/store router.
// Aligned accesses go either to the variable-latency data RAM (req/ack, pipeline
// stalled while outstanding) or to a small single-cycle peripheral bank holding
// a reloading timer, an LED register and the board switches.
module mem_access_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Mem_in,
    input  logic [31:0] Mem_BusB,
    input  logic        Mem_MemRd,
    input  logic        Mem_MemWr,
    input  logic        ram_ack,
    input  logic [31:0] ram_rdata,
    input  logic [7:0]  switch,
    output logic        ram_req,
    output logic        ram_we,
    output logic [31:0] ram_addr,
    output logic [31:0] ram_wdata,
    output logic        mem_stall,
    output logic [31:0] Mem_ReadData,
    output logic [7:0]  led,
    output logic        irq,
    output logic        addr_err
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Word index of each peripheral register inside the 0x4000_00xx window
    localparam int          NUM_PREG = 5;
    localparam logic [2:0]  IDX_TH   = 3'd0;
    localparam logic [2:0]  IDX_TL   = 3'd1;
    localparam logic [2:0]  IDX_TCON = 3'd2;
    localparam logic [2:0]  IDX_LED  = 3'd3;
    localparam logic [2:0]  IDX_SW   = 3'd4;
    localparam logic [31:0] TL_MAX   = 32'hFFFF_FFFF;

    state_t      state_reg, state_next;
    logic [31:0] rdata_reg;

    logic [31:0] th_reg, th_next;
    logic [31:0] tl_reg, tl_next;
    logic [2:0]  tcon_reg, tcon_next;
    logic [7:0]  led_reg, led_next;

    logic        access;
    logic        aligned;
    logic        in_periph;
    logic        periph_hit;
    logic [2:0]  word_idx;
    logic        idle_slot;
    logic        ram_start;
    logic        periph_wr;
    logic        periph_rd;
    logic [NUM_PREG-1:0] wr_sel;
    logic [31:0] periph_rdata;
    logic        tl_wrap;

    // Address decode of the instruction currently in MEM
    assign access     = Mem_MemRd | Mem_MemWr;
    assign aligned    = (Mem_in[1:0] == 2'b00);
    assign in_periph  = (Mem_in[31:28] == 4'h4);
    assign word_idx   = Mem_in[4:2];
    assign periph_hit = in_periph && (Mem_in[27:5] == 23'd0) && (word_idx <= IDX_SW);

    // Only an instruction evaluated in IDLE is new; WAIT/DONE belong to a RAM access
    assign idle_slot  = (state_reg == ST_IDLE);
    assign ram_start  = idle_slot && access && aligned && !in_periph;
    assign periph_wr  = idle_slot && Mem_MemWr && aligned && periph_hit;
    assign periph_rd  = idle_slot && Mem_MemRd && aligned && periph_hit;

    // One write strobe per peripheral register
    generate
        for (genvar gi = 0; gi < NUM_PREG; gi++) begin : g_wr_sel
            assign wr_sel[gi] = periph_wr && (word_idx == 3'(gi));
        end
    endgenerate

    // RAM side sees the frozen EX/MEM values directly
    assign ram_addr  = Mem_in;
    assign ram_wdata = Mem_BusB;
    assign ram_we    = ram_req & Mem_MemWr;

    assign led = led_reg;
    assign irq = tcon_reg[2];

    assign tl_wrap = tcon_reg[0] && (tl_reg == TL_MAX);

    // Peripheral register next-state: software writes win over the timer
    always_comb begin
        th_next   = th_reg;
        tl_next   = tl_reg;
        tcon_next = tcon_reg;
        led_next  = led_reg;

        if (wr_sel[IDX_TH]) begin
            th_next = Mem_BusB;
        end

        if (wr_sel[IDX_LED]) begin
            led_next = Mem_BusB[7:0];
        end

        if (wr_sel[IDX_TL]) begin
            tl_next = Mem_BusB;
        end else if (tcon_reg[0]) begin
            tl_next = tl_wrap ? th_reg : (tl_reg + 32'd1);
        end

        // A TL write cancels the whole overflow event, including the irq set
        if (wr_sel[IDX_TCON]) begin
            tcon_next = Mem_BusB[2:0];
        end else if (tl_wrap && tcon_reg[1] && !wr_sel[IDX_TL]) begin
            tcon_next[2] = 1'b1;
        end
    end

    // Peripheral register state
    always_ff @(posedge clk) begin
        if (reset) begin
            th_reg   <= '0;
            tl_reg   <= '0;
            tcon_reg <= '0;
            led_reg  <= '0;
        end else begin
            th_reg   <= th_next;
            tl_reg   <= tl_next;
            tcon_reg <= tcon_next;
            led_reg  <= led_next;
        end
    end

    // Peripheral read mux; unmapped words read as zero
    always_comb begin
        periph_rdata = '0;
        case (word_idx)
            IDX_TH:   periph_rdata = th_reg;
            IDX_TL:   periph_rdata = tl_reg;
            IDX_TCON: periph_rdata = {29'd0, tcon_reg};
            IDX_LED:  periph_rdata = {24'd0, led_reg};
            IDX_SW:   periph_rdata = {24'd0, switch};
            default:  periph_rdata = '0;
        endcase
    end

    // RAM handshake state and captured load data
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= ST_IDLE;
            rdata_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (state_reg == ST_WAIT && ram_ack) begin
                rdata_reg <= ram_rdata;
            end
        end
    end

    // RAM FSM next-state and MEM-stage outputs
    always_comb begin
        state_next   = state_reg;
        ram_req      = 1'b0;
        mem_stall    = 1'b0;
        Mem_ReadData = '0;
        addr_err     = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                addr_err = access && !aligned;
                if (ram_start) begin
                    ram_req    = 1'b1;
                    mem_stall  = 1'b1;
                    state_next = ST_WAIT;
                end else if (periph_rd) begin
                    Mem_ReadData = periph_rdata;
                end
            end
            ST_WAIT: begin
                ram_req   = 1'b1;
                mem_stall = 1'b1;
                if (ram_ack) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                if (Mem_MemRd) begin
                    Mem_ReadData = rdata_reg;
                end
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

MEM-stage access unit: consumer of the EX/MEM pipeline register outputs. Decodes the latched ALU result as a data address and routes each load/store either to the variable-latency data RAM over a req/ack handshake or to an on-chip peripheral bank (timer, LEDs, switches). Stalls the front of the pipeline while a RAM access is outstanding and returns load data to the MEM/WB register.

## Interface
- No parameters.
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  synchronous, active-high
- Mem_in  in  32  byte address (ALU result latched in EX/MEM)
- Mem_BusB  in  32  store data
- Mem_MemRd  in  1  load in MEM stage
- Mem_MemWr  in  1  store in MEM stage
- ram_ack  in  1  RAM completion; sampled only in WAIT
- ram_rdata  in  32  RAM read data, valid with ram_ack
- switch  in  8  board switches, read-only peripheral
- ram_req  out  1  RAM request
- ram_we  out  1  1 = write
- ram_addr  out  32  word-aligned address (= Mem_in)
- ram_wdata  out  32  = Mem_BusB
- mem_stall  out  1  hold PC, IF/ID, ID/EX, EX/MEM; bubble into MEM/WB
- Mem_ReadData  out  32  load result to MEM/WB
- led  out  8  LED register
- irq  out  1  timer interrupt (= TCON[2])
- addr_err  out  1  one-cycle pulse on misaligned access

## Operation
- Access = Mem_MemRd | Mem_MemWr. Peripheral region: Mem_in[31:28]==4'h4; all other addresses are RAM.
- Misaligned (Mem_in[1:0]!=0): access suppressed (no req, no peripheral write, Mem_ReadData=0), addr_err=1 for that cycle, no stall.
- Peripheral map (single-cycle, never stalls): 0x40000000 TH rw; 0x40000004 TL rw; 0x40000008 TCON[2:0] rw (bit0 enable, bit1 irq-enable, bit2 irq status), upper bits read 0; 0x4000000C led[7:0] rw; 0x40000010 switch read-only, writes ignored; other peripheral addresses read 0, writes ignored.
- Peripheral load: Mem_ReadData combinational from register/switch in the same cycle.
- Timer: while TCON[0]=1, TL increments each cycle; when TL==32'hFFFFFFFF, TL<=TH and, if TCON[1]=1, TCON[2]<=1. TCON[2] cleared only by software write.
- Simultaneous events: software write to TL or TCON beats timer update that cycle; write to TH takes effect on next reload.
- RAM FSM states: IDLE, WAIT, DONE.
  - IDLE: if RAM access and aligned -> WAIT; ram_req=1, mem_stall=1 this cycle.
  - WAIT: ram_req=1, ram_we/addr/wdata held (EX/MEM frozen); mem_stall=1; on ram_ack -> DONE, capture ram_rdata into rdata_q.
  - DONE: ram_req=0, mem_stall=0, Mem_ReadData=rdata_q for loads (0 for stores); -> IDLE unconditionally.
- ram_we = Mem_MemWr whenever ram_req=1; ram_req never asserted for peripheral accesses.
- Mem_ReadData = 0 when no load is in MEM.
- ram_ack outside WAIT ignored.

## Timing
- Reset values: state IDLE, ram_req 0, mem_stall 0, rdata_q 0, TH 0, TL 0, TCON 0, led 0, irq 0, addr_err 0, Mem_ReadData 0.
- Reset mid-access (WAIT or DONE): state to IDLE next edge, ram_req drops, captured data discarded.
- RAM access with ack in first WAIT cycle: instruction occupies MEM 3 cycles (IDLE, WAIT, DONE) = 2 stall cycles; each extra ack-less WAIT cycle adds one stall.
- Instruction leaves MEM at the edge ending DONE; the next instruction is evaluated in IDLE the following cycle, so back-to-back RAM accesses never overlap.
- Peripheral access: 1 cycle, stored value visible to a load in the next cycle.
- Timer reload and irq set take effect at the edge when TL==FFFFFFFF is observed.

## Test plan
- Reset: assert reset 2 cycles mid-WAIT -> ram_req=0, mem_stall=0, led=0, TL=0, state IDLE.
- RAM load 0x00000010, ack after 3 WAIT cycles with rdata 0xDEADBEEF -> mem_stall high 4 cycles, then Mem_ReadData=0xDEADBEEF for one cycle, ram_req low.
- RAM store 0x00000020 data 0x12345678, ack first WAIT cycle -> ram_we=1, ram_wdata stable during req, 2 stall cycles.
- Timer: TH=0xFFFFFFFD, TL=0xFFFFFFFD, TCON=3 -> TL FFFFFFFE, FFFFFFFF, then FFFFFFFD with irq=1; store TCON=1 -> irq=0.
- Collision: store TL=0x5 in same cycle TL overflows -> TL=0x5, irq unchanged.
- Misaligned load 0x00000012 -> addr_err pulse 1 cycle, no ram_req, no stall, Mem_ReadData=0; store 0x4000000C data 0xA5 -> led=0xA5, no stall.
